// File: rtl/mema_seq.sv
// Sequencer for the skewed A-operand buffer: loads DIM rows over valid/ready,
// then drives memA shift and array compute enables for a fixed drain window.
module mema_seq #(
  parameter int DIM   = 8,
  parameter int DRAIN = 3*DIM-2,
  localparam int RW   = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int DW   = $clog2(DRAIN+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          row_valid,
  output logic          row_ready,
  output logic          a_wren,
  output logic [RW-1:0] a_row,
  output logic          a_en,
  output logic          sa_en,
  output logic          sa_clr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [RW-1:0] row_cnt;
  logic [DW-1:0] drain_cnt;
  logic          clr_q;

  // Counters are cleared on every exit so a_row reads 0 outside LOAD and
  // neither counter ever wraps inside a pass; abort outranks the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
      clr_q     <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            row_cnt <= '0;
            clr_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state   <= S_IDLE;
            row_cnt <= '0;
          end else if (row_valid) begin
            if (row_cnt == RW'(DIM-1)) begin
              state     <= S_DRAIN;
              row_cnt   <= '0;
              drain_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
          end else if (drain_cnt == DW'(DRAIN-1)) begin
            state     <= S_DONE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign row_ready = (state == S_LOAD);
  assign a_wren    = row_valid & row_ready;
  assign a_row     = row_cnt;
  assign a_en      = (state == S_DRAIN);
  assign sa_en     = (state == S_DRAIN);
  assign sa_clr    = clr_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_mema_seq.sv
// Directed bench for mema_seq at DIM=4, DRAIN=10; expected outputs per cycle
// are hand-derived timelines relative to the cycle in which start is driven.
module tb_mema_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       row_valid;
  logic       row_ready;
  logic       a_wren;
  logic [1:0] a_row;
  logic       a_en;
  logic       sa_en;
  logic       sa_clr;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  mema_seq #(.DIM(4), .DRAIN(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .a_wren    (a_wren),
    .a_row     (a_row),
    .a_en      (a_en),
    .sa_en     (sa_en),
    .sa_clr    (sa_clr),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {row_ready, a_wren, a_row[1:0], a_en, sa_en, sa_clr, busy, done}.
  function automatic logic [8:0] pack(input logic rdy, input logic wr, input logic [1:0] row,
                                      input logic en, input logic clr, input logic bsy,
                                      input logic dn);
    return {rdy, wr, row, en, en, clr, bsy, dn};
  endfunction

  function automatic logic [8:0] observed();
    return {row_ready, a_wren, a_row, a_en, sa_en, sa_clr, busy, done};
  endfunction

  // Nominal pass timeline, k = cycles since start was driven: rows 1..4,
  // drain 5..14, done 15, idle afterwards.
  function automatic logic [8:0] nomExp(input int k);
    logic rdy;
    rdy = (k >= 1 && k <= 4);
    return pack(rdy, rdy, rdy ? 2'(k-1) : 2'd0, (k >= 5 && k <= 14), (k == 1),
                (k >= 1 && k <= 15), (k == 15));
  endfunction

  // Stalled load: row_valid low on cycles 2 and 3.
  function automatic logic [8:0] stallExp(input int c);
    logic       rdy;
    logic [1:0] row;
    rdy = (c >= 1 && c <= 6);
    case (c)
      2, 3, 4: row = 2'd1;
      5:       row = 2'd2;
      6:       row = 2'd3;
      default: row = 2'd0;
    endcase
    return pack(rdy, rdy && c != 2 && c != 3, row, (c >= 7 && c <= 16), (c == 1),
                (c >= 1 && c <= 17), (c == 17));
  endfunction

  task automatic checkOutput(input string tag, input int c, input logic [8:0] obs,
                             input logic [8:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b (rdy wr row en en clr busy done)",
               tag, c, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic v, input logic r);
    start     = s;
    abort     = a;
    row_valid = v;
    rst       = r;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #4;
    checkOutput(tag, -1, observed(), 9'b0);
    nextCycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    #4;
    checkOutput("reset_hold", -1, observed(), 9'b0);
    nextCycle();

    doReset("reset_nom");
    for (int c = 0; c <= 17; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b1, 1'b0);
      #4;
      checkOutput("nominal", c, observed(), nomExp(c));
      nextCycle();
    end

    doReset("reset_stall");
    for (int c = 0; c <= 19; c++) begin
      applyStimulus(c == 0, 1'b0, !(c == 2 || c == 3), 1'b0);
      #4;
      checkOutput("stall", c, observed(), stallExp(c));
      nextCycle();
    end

    // Start+abort together in IDLE (start wins), start repeated in LOAD and
    // DRAIN, abort in DONE: all must leave the nominal timeline untouched.
    doReset("reset_ign");
    for (int c = 0; c <= 18; c++) begin
      applyStimulus(c == 0 || c == 2 || c == 8, c == 0 || c == 15, 1'b1, 1'b0);
      #4;
      checkOutput("ignored_ctl", c, observed(), nomExp(c));
      nextCycle();
    end

    // Abort on the final row handshake, then a clean pass from cycle 21.
    doReset("reset_abt");
    for (int c = 0; c <= 38; c++) begin
      applyStimulus(c == 0 || c == 21, c == 4, 1'b1, 1'b0);
      #4;
      if (c <= 4)
        checkOutput("abort_load", c, observed(), nomExp(c));
      else if (c <= 20)
        checkOutput("abort_idle", c, observed(), 9'b0);
      else
        checkOutput("after_abort", c, observed(), nomExp(c-21));
      nextCycle();
    end

    doReset("reset_abd");
    for (int c = 0; c <= 16; c++) begin
      applyStimulus(c == 0, c == 10, 1'b1, 1'b0);
      #4;
      checkOutput("abort_drain", c, observed(), (c <= 10) ? nomExp(c) : 9'b0);
      nextCycle();
    end

    // Reset in DRAIN with start also high: reset wins, then a new pass at 10.
    doReset("reset_mid");
    for (int c = 0; c <= 27; c++) begin
      applyStimulus(c == 0 || c == 8 || c == 10, 1'b0, 1'b1, c == 8);
      #4;
      if (c <= 8)
        checkOutput("pre_rst", c, observed(), nomExp(c));
      else
        checkOutput("post_rst", c, observed(), nomExp(c-10));
      nextCycle();
    end

    doReset("reset_b2b");
    for (int c = 0; c <= 31; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      #4;
      checkOutput("b2b", c, observed(), (c <= 15) ? nomExp(c) : nomExp(c-16));
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
